shift_div: RTL and testbench

Sequential restoring divider, the inverse of the team's shift-add multiplier datapath. It takes an unsigned N-bit dividend and divisor on a start pulse. It then performs one shift-subtract iteration per clock for N clocks and returns an N-bit quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic unit and uses the same start/result style.

---
 rtl/shift_div_pkg.sv | 11 +
 rtl/shift_div_step.sv | 25 ++
 rtl/shift_div.sv | 103 ++++++++++
 tb/tb_shift_div.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/shift_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package shift_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Width needed to hold the iteration count N.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_div_step.sv
// One restoring shift-subtract iteration, purely combinational.
module shift_div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   rem,
  input  logic [N-1:0] quo,
  input  logic [N-1:0] dsr,
  output logic [N:0]   rem_nx,
  output logic [N-1:0] quo_nx
);

  logic [N+1:0] sh;
  logic [N+1:0] trial;

  // rem stays below dsr, so its top bit is always 0; the extra bit keeps the
  // subtraction sign in trial's MSB without a separate carry.
  assign sh    = {rem, quo[N-1]};
  assign trial = sh - {2'b00, dsr};

  always_comb begin
    quo_nx = {quo[N-2:0], ~trial[N+1]};
    rem_nx = trial[N+1] ? sh[N:0] : trial[N:0];
  end

endmodule

// File: rtl/shift_div.sv
// Sequential restoring divider: N clocks per quotient, start/busy/done handshake.
module shift_div
  import shift_div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);

  state_t         state, state_nx;
  logic [N:0]     rem, rem_nx;
  logic [N-1:0]   quo, quo_nx, dsr;
  logic [CW-1:0]  cnt;
  logic           zero_pend;
  logic           accept, nz, last;

  // A divide-by-zero request spends one cycle in zero_pend before DONE; new
  // requests are held off during that cycle.
  assign accept = start && (state != RUN) && !zero_pend;
  assign nz     = |divisor;
  assign last   = (state == RUN) && (cnt == CW'(1));

  shift_div_step #(.N(N)) u_step (
    .rem    (rem),
    .quo    (quo),
    .dsr    (dsr),
    .rem_nx (rem_nx),
    .quo_nx (quo_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (zero_pend)        state_nx = DONE;
               else if (accept && nz) state_nx = RUN;
      RUN:     if (last)             state_nx = DONE;
      DONE:    state_nx = (accept && nz) ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      quo         <= '0;
      dsr         <= '0;
      cnt         <= '0;
      zero_pend   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        quo <= dividend;
        if (nz) begin
          rem <= '0;
          dsr <= divisor;
          cnt <= CW'(N);
        end else begin
          zero_pend <= 1'b1;
        end
      end
      if (zero_pend) begin
        zero_pend   <= 1'b0;
        quotient    <= '1;
        remainder   <= quo;
        div_by_zero <= 1'b1;
      end
      if (state == RUN) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt - CW'(1);
        if (last) begin
          quotient    <= quo_nx;
          remainder   <= rem_nx[N-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_div.sv
// Directed bench for shift_div (N=4): vector table, back-to-back sweep, corner sequences.
module tb_shift_div;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int nchk = 0;
  int nfail = 0;

  shift_div #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a, b;
    int q, r, z;
    int lat;   // negedges after the accepting edge until done is seen
    int bsy;   // cycles busy was high before done
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done; returns latency and busy count.
  task automatic do_div(input int a, input int b, output int lat, output int bsy);
    @(negedge clk);
    start = 1'b1; dividend = N'(a); divisor = N'(b);
    @(negedge clk);
    start = 1'b0;
    lat = 1; bsy = 0;
    while (!done && lat < 20) begin
      bsy += int'(busy);
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vt[8];

  initial begin
    int lat, bsy, n, pa, pb;
    bit first;

    vt[0] = '{13, 3,  4, 1, 0, 5, 4};
    vt[1] = '{ 5, 7,  0, 5, 0, 5, 4};
    vt[2] = '{15, 1, 15, 0, 0, 5, 4};
    vt[3] = '{ 9, 0, 15, 9, 1, 2, 0};
    vt[4] = '{ 8, 2,  4, 0, 0, 5, 4};
    vt[5] = '{ 0, 5,  0, 0, 0, 5, 4};
    vt[6] = '{15, 15, 1, 0, 0, 5, 4};
    vt[7] = '{ 7, 15, 0, 7, 0, 5, 4};

    // Reset state
    #2;
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_div(vt[i].a, vt[i].b, lat, bsy);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), bsy, vt[i].bsy);
      chk($sformatf("v%0d_quotient", i), int'(quotient), vt[i].q);
      chk($sformatf("v%0d_remainder", i), int'(remainder), vt[i].r);
      chk($sformatf("v%0d_dbz", i), int'(div_by_zero), vt[i].z);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), int'(done), 0);
    end

    // Back-to-back sweep: each new start is raised in the done cycle
    first = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        if (first) @(negedge clk);
        first = 1'b0;
        start = 1'b1; dividend = N'(a); divisor = N'(b);
        pa = a; pb = b;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk($sformatf("sw_%0d_%0d_gap", pa, pb), n, 5);
        chk($sformatf("sw_%0d_%0d_q", pa, pb), int'(quotient), pa / pb);
        chk($sformatf("sw_%0d_%0d_r", pa, pb), int'(remainder), pa % pb);
      end
    end
    @(negedge clk);

    // Start during RUN is ignored
    @(negedge clk);
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0; n = 1;
    @(negedge clk);
    start = 1'b1; dividend = 4'd15; divisor = 4'd1; n++;
    @(negedge clk);
    start = 1'b0; n++;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ign_latency", n, 5);
    chk("ign_quotient", int'(quotient), 2);
    chk("ign_remainder", int'(remainder), 2);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n += int'(done);
    end
    chk("ign_extra_done", n, 0);

    // Reset in the second RUN cycle
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_quotient", int'(quotient), 0);
    chk("mid_rst_remainder", int'(remainder), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n += int'(done) + int'(busy);
    end
    chk("mid_rst_no_done", n, 0);
    do_div(14, 3, lat, bsy);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_quotient", int'(quotient), 4);
    chk("post_rst_remainder", int'(remainder), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
